// File: rtl/me_pkg.sv
// Shared constants and state type for the motion-estimation search controller.
package me_pkg;

  localparam int N_PE      = 16;
  localparam int BLK_SIZE  = 16;
  localparam int SRCH_SIZE = 32;

  localparam logic [12:0] LAST_CNT      = 13'd4111;
  localparam logic [12:0] LAST_ADDR_CNT = 13'd4095;
  localparam logic [12:0] FIRST_RESULT  = 13'd256;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } me_state_t;

endpackage

// File: rtl/me_addr_gen.sv
// Maps the search counter onto reference/search memory addresses and the per-PE
// S1/S2 source select. Addresses freeze once the counter passes the last address.
module me_addr_gen
  import me_pkg::*;
#(
  parameter int N_PE = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic              active,
  input  logic [12:0]       cnt,
  output logic [7:0]        AddressR,
  output logic [9:0]        AddressS1,
  output logic [9:0]        AddressS2,
  output logic [N_PE-1:0]   S1S2mux
);

  logic        live;
  logic [11:0] idx_d, idx_q;
  logic [4:0]  row_sum;

  always_comb begin
    live    = run && (cnt <= LAST_ADDR_CNT);
    idx_d   = live ? cnt[11:0] : idx_q;
    row_sum = {1'b0, idx_d[11:8]} + {1'b0, idx_d[7:4]};

    AddressR  = '0;
    AddressS1 = '0;
    AddressS2 = '0;
    // (vy+r)*32 + c, with the right half sitting 16 columns further on
    if (active) begin
      AddressR  = idx_d[7:0];
      AddressS1 = {row_sum, 1'b0, idx_d[3:0]};
      AddressS2 = {row_sum, 1'b1, idx_d[3:0]};
    end

    S1S2mux = '0;
    for (int k = 0; k < N_PE; k++) begin
      S1S2mux[k] = run && (cnt[3:0] >= 4'(k));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) idx_q <= '0;
    else       idx_q <= idx_d;
  end

endmodule

// File: rtl/me_control.sv
// Full-search block-matching sequencer: FSM, search counter and per-PE strobes.
// Optional build macro ME_ABORT_EN adds an abort input that cancels a running search.
module me_control
  import me_pkg::*;
#(
  parameter int N_PE = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [7:0]        AddressR,
  output logic [9:0]        AddressS1,
  output logic [9:0]        AddressS2,
  output logic [N_PE-1:0]   S1S2mux,
  output logic [N_PE-1:0]   newDist,
  output logic [N_PE-1:0]   PEready,
  output logic              CompStart,
  output logic [3:0]        VectorX,
  output logic [3:0]        VectorY,
`ifdef ME_ABORT_EN
  input  logic              abort,
`endif
  output logic              completed
);

  me_state_t   state_d, state_q;
  logic [12:0] cnt_d, cnt_q;
  logic [3:0]  vx_d, vx_q, vy_d, vy_q;
  logic        run, blk_hit, nd_hit, pe_hit, abort_w;

`ifdef ME_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: if (start) begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
      ST_RUN: begin
        if (abort_w)                state_d = ST_IDLE;
        else if (cnt_q == LAST_CNT) state_d = ST_DONE;
        else                        cnt_d   = cnt_q + 13'd1;
      end
      ST_DONE: if (!start) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // PE k sees block boundary m when cnt = 256*m + k, so only cnt[7:4]==0 can strobe
  always_comb begin
    run     = (state_q == ST_RUN);
    blk_hit = run && (cnt_q[7:4] == 4'd0);
    nd_hit  = blk_hit && !cnt_q[12];
    pe_hit  = blk_hit && (cnt_q[12:8] != 5'd0);

    newDist = nd_hit ? ({{(N_PE-1){1'b0}}, 1'b1} << cnt_q[3:0]) : '0;
    PEready = pe_hit ? ({{(N_PE-1){1'b0}}, 1'b1} << cnt_q[3:0]) : '0;

    // block 16 wraps to 0 in cnt[11:8], so the decrement still yields 15
    vx_d    = pe_hit ? cnt_q[3:0] : vx_q;
    vy_d    = pe_hit ? (cnt_q[11:8] - 4'd1) : vy_q;
    VectorX = vx_d;
    VectorY = vy_d;

    CompStart = run && (cnt_q >= FIRST_RESULT);
    completed = (state_q == ST_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      vx_q    <= '0;
      vy_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vx_q    <= vx_d;
      vy_q    <= vy_d;
    end
  end

  me_addr_gen #(.N_PE(N_PE)) u_addr_gen (
    .clk       (clk),
    .reset     (reset),
    .run       (run),
    .active    (state_q != ST_IDLE),
    .cnt       (cnt_q),
    .AddressR  (AddressR),
    .AddressS1 (AddressS1),
    .AddressS2 (AddressS2),
    .S1S2mux   (S1S2mux)
  );

endmodule

// File: tb/tb_me_control.sv
// Self-checking bench for me_control against a cycle-level behavioural model.
module tb_me_control;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [7:0]  AddressR;
  logic [9:0]  AddressS1, AddressS2;
  logic [15:0] S1S2mux, newDist, PEready;
  logic        CompStart, completed;
  logic [3:0]  VectorX, VectorY;
`ifdef ME_ABORT_EN
  logic        abort;
`endif

  me_control #(.N_PE(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .AddressR  (AddressR),
    .AddressS1 (AddressS1),
    .AddressS2 (AddressS2),
    .S1S2mux   (S1S2mux),
    .newDist   (newDist),
    .PEready   (PEready),
    .CompStart (CompStart),
    .VectorX   (VectorX),
    .VectorY   (VectorY),
`ifdef ME_ABORT_EN
    .abort     (abort),
`endif
    .completed (completed)
  );

  always #5 clk = ~clk;

  logic [85:0] dut_o, exp_o;
  assign dut_o = {AddressR, AddressS1, AddressS2, S1S2mux, newDist, PEready,
                  CompStart, VectorX, VectorY, completed};

  int n_tests = 0;
  int n_fail  = 0;

  // model: phase 0=idle 1=run 2=done
  int m_ph, m_cnt, m_idx, m_vx, m_vy;

  task automatic model_reset();
    m_ph = 0; m_cnt = 0; m_idx = 0; m_vx = 0; m_vy = 0;
  endtask

  function automatic logic [85:0] model_eval();
    int t, s1;
    logic [7:0]  ar;
    logic [9:0]  a1, a2;
    logic [15:0] mx, nd, pr;
    logic        cs;
    ar = '0; a1 = '0; a2 = '0; mx = '0; nd = '0; pr = '0; cs = 1'b0;
    if (m_ph == 1) begin
      if (m_cnt <= 4095) m_idx = m_cnt;
      for (int k = 0; k < 16; k++) begin
        t = m_cnt - k;
        mx[k] = ((m_cnt % 16) >= k);
        if (t >= 0 && t <= 4095 && (t % 256) == 0) nd[k] = 1'b1;
        if (t >= 256 && t <= 4096 && (t % 256) == 0) begin
          pr[k] = 1'b1;
          m_vx  = k;
          m_vy  = t / 256 - 1;
        end
      end
      cs = (m_cnt >= 256);
    end
    if (m_ph != 0) begin
      s1 = ((m_idx / 256) + ((m_idx / 16) % 16)) * 32 + (m_idx % 16);
      ar = 8'(m_idx % 256);
      a1 = 10'(s1);
      a2 = 10'(s1 + 16);
    end
    return {ar, a1, a2, mx, nd, pr, cs, 4'(m_vx), 4'(m_vy), (m_ph == 2)};
  endfunction

  task automatic tick();
    bit st, ab;
    st = start;
    ab = 1'b0;
`ifdef ME_ABORT_EN
    ab = abort;
`endif
    @(posedge clk);
    if (reset) model_reset();
    else begin
      case (m_ph)
        0: if (st) begin m_ph = 1; m_cnt = 0; end
        1: if (ab) m_ph = 0;
           else if (m_cnt == 4111) m_ph = 2;
           else m_cnt++;
        default: if (!st) m_ph = 0;
      endcase
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0;
    #3;
    model_reset();
    exp_o = model_eval();
    n_tests++;
    if (dut_o !== exp_o) begin
      n_fail++; $display("FAIL reset_state got=%h exp=%h", dut_o, exp_o);
    end
    repeat (3) tick();
    #2 reset = 1'b0;
    repeat ($urandom_range(4, 12)) begin
      tick(); exp_o = model_eval(); n_tests++;
      if (dut_o !== exp_o) begin
        n_fail++; $display("FAIL idle_no_start got=%h exp=%h", dut_o, exp_o);
      end
    end
  endtask

  task automatic test_full_run();
    int n, pe_n, first_cnt, last_cnt, uniq;
    logic [3:0] fx, fy, lx, ly;
    int seen[256];
    bit done;
    foreach (seen[i]) seen[i] = 0;
    pe_n = 0; first_cnt = -1; last_cnt = -1; fx = '1; fy = '1; lx = '0; ly = '0;
    repeat ($urandom_range(1, 20)) begin
      tick(); exp_o = model_eval(); n_tests++;
      if (dut_o !== exp_o) begin
        n_fail++; $display("FAIL full_pre_idle got=%h exp=%h", dut_o, exp_o);
      end
    end
    start = 1'b1; tick(); start = 1'b0;
    n = 1; done = 1'b0;
    while (!done && n < 5000) begin
      exp_o = model_eval(); n_tests++;
      if (dut_o !== exp_o) begin
        n_fail++; $display("FAIL full_cycle n=%0d cnt=%0d got=%h exp=%h", n, m_cnt, dut_o, exp_o);
      end
      if (m_ph == 1 && m_cnt == 0) begin
        n_tests++;
        if ({AddressR, AddressS1, AddressS2, newDist} !== {8'h00, 10'd0, 10'd16, 16'h0001}) begin
          n_fail++; $display("FAIL first_addr got=%h/%0d/%0d/%h exp=00/0/16/0001",
                             AddressR, AddressS1, AddressS2, newDist);
        end
      end
      if (m_ph == 1 && m_cnt == 'h123) begin
        n_tests++;
        if ({AddressR, AddressS1, AddressS2, S1S2mux} !== {8'h23, 10'd99, 10'd115, 16'h000F}) begin
          n_fail++; $display("FAIL cnt_123 got=%h/%0d/%0d/%h exp=23/99/115/000f",
                             AddressR, AddressS1, AddressS2, S1S2mux);
        end
      end
      if (PEready != 16'h0) begin
        pe_n++;
        if (pe_n == 1) begin first_cnt = m_cnt; fx = VectorX; fy = VectorY; end
        last_cnt = m_cnt; lx = VectorX; ly = VectorY;
        seen[int'({VectorX, VectorY})]++;
      end
      if (completed) begin
        done = 1'b1;
        n_tests++;
        if (n != 4113) begin
          n_fail++; $display("FAIL latency got=%0d exp=4113", n);
        end
      end else begin
        tick(); n++;
      end
    end
    if (!done) begin
      n_tests++; n_fail++; $display("FAIL full_timeout completed never rose after %0d cycles", n);
    end
    uniq = 0;
    foreach (seen[i]) if (seen[i] == 1) uniq++;
    n_tests++;
    if (pe_n != 256 || uniq != 256) begin
      n_fail++; $display("FAIL peready_count got=%0d pulses %0d unique pairs exp=256 256", pe_n, uniq);
    end
    n_tests++;
    if (first_cnt != 256 || fx !== 4'd0 || fy !== 4'd0) begin
      n_fail++; $display("FAIL first_result got cnt=%0d x=%0d y=%0d exp 256 0 0", first_cnt, fx, fy);
    end
    n_tests++;
    if (last_cnt != 4111 || lx !== 4'd15 || ly !== 4'd15) begin
      n_fail++; $display("FAIL last_result got cnt=%0d x=%0d y=%0d exp 4111 15 15", last_cnt, lx, ly);
    end
    tick(); exp_o = model_eval(); n_tests++;
    if (dut_o !== exp_o) begin
      n_fail++; $display("FAIL full_back_idle got=%h exp=%h", dut_o, exp_o);
    end
  endtask

  task automatic test_reset_mid(input int target);
    int g;
    start = 1'b1; tick(); start = 1'b0;
    exp_o = model_eval();
    g = 0;
    while (m_ph == 1 && m_cnt < target && g < 5000) begin
      tick(); exp_o = model_eval(); g++;
    end
    n_tests++;
    if (dut_o !== exp_o || m_cnt != target) begin
      n_fail++; $display("FAIL rmid_reach cnt=%0d target=%0d got=%h exp=%h", m_cnt, target, dut_o, exp_o);
    end
    #2 reset = 1'b1;
    #1 model_reset();
    exp_o = model_eval(); n_tests++;
    if (dut_o !== exp_o) begin
      n_fail++; $display("FAIL rmid_async got=%h exp=%h", dut_o, exp_o);
    end
    repeat (2) tick();
    #2 reset = 1'b0;
    repeat ($urandom_range(3, 10)) begin
      tick(); exp_o = model_eval(); n_tests++;
      if (dut_o !== exp_o) begin
        n_fail++; $display("FAIL rmid_stays_idle got=%h exp=%h", dut_o, exp_o);
      end
    end
    start = 1'b1; tick(); start = 1'b0;
    exp_o = model_eval(); n_tests++;
    if ({AddressR, AddressS1, AddressS2, newDist, completed} !== {8'h00, 10'd0, 10'd16, 16'h0001, 1'b0}) begin
      n_fail++; $display("FAIL rmid_restart got=%h/%0d/%0d/%h exp=00/0/16/0001", AddressR, AddressS1, AddressS2, newDist);
    end
    repeat (300) begin
      tick(); exp_o = model_eval(); n_tests++;
      if (dut_o !== exp_o) begin
        n_fail++; $display("FAIL rmid_rerun cnt=%0d got=%h exp=%h", m_cnt, dut_o, exp_o);
      end
    end
    #2 reset = 1'b1;
    #1 model_reset();
    tick();
    #2 reset = 1'b0;
  endtask

  task automatic test_start_held();
    int g;
    start = 1'b1;
    g = 0;
    while (m_ph != 2 && g < 5000) begin
      tick(); exp_o = model_eval(); n_tests++; g++;
      if (dut_o !== exp_o) begin
        n_fail++; $display("FAIL held_run cnt=%0d got=%h exp=%h", m_cnt, dut_o, exp_o);
      end
    end
    if (m_ph != 2) begin
      n_tests++; n_fail++; $display("FAIL held_timeout completed never rose");
    end
    repeat ($urandom_range(3, 30)) begin
      tick(); exp_o = model_eval(); n_tests++;
      if (dut_o !== exp_o || completed !== 1'b1) begin
        n_fail++; $display("FAIL held_done got=%h exp=%h", dut_o, exp_o);
      end
    end
    start = 1'b0;
    repeat ($urandom_range(5, 20)) begin
      tick(); exp_o = model_eval(); n_tests++;
      if (dut_o !== exp_o || completed !== 1'b0) begin
        n_fail++; $display("FAIL held_release got=%h exp=%h", dut_o, exp_o);
      end
    end
  endtask

`ifdef ME_ABORT_EN
  task automatic test_abort(input int target);
    int g;
    start = 1'b1; tick(); start = 1'b0;
    exp_o = model_eval();
    g = 0;
    while (m_ph == 1 && m_cnt < target && g < 5000) begin
      tick(); exp_o = model_eval(); g++;
      if (completed !== 1'b0) begin
        n_tests++; n_fail++; $display("FAIL abort_early_done cnt=%0d got=%b exp=0", m_cnt, completed);
      end
    end
    abort = 1'b1; tick(); abort = 1'b0;
    exp_o = model_eval(); n_tests++;
    if (dut_o !== exp_o || completed !== 1'b0) begin
      n_fail++; $display("FAIL abort_at_%0d got=%h exp=%h", target, dut_o, exp_o);
    end
    repeat ($urandom_range(3, 10)) begin
      tick(); exp_o = model_eval(); n_tests++;
      if (dut_o !== exp_o) begin
        n_fail++; $display("FAIL abort_idle got=%h exp=%h", dut_o, exp_o);
      end
    end
  endtask
`endif

  initial begin
    reset = 1'b1;
    start = 1'b0;
`ifdef ME_ABORT_EN
    abort = 1'b0;
`endif
    model_reset();
    test_reset();
    test_full_run();
    test_reset_mid(2000);
    test_reset_mid($urandom_range(1, 3800));
    test_start_held();
`ifdef ME_ABORT_EN
    test_abort(500);
    test_abort(4111);
    test_abort($urandom_range(1, 4110));
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
